// File: rtl/ctrl_ld_pingpong_if.sv
// rtl/ctrl_ld_pingpong_if.sv - load-side stream, buffer-write and bank handshake bundle
interface ctrl_ld_pingpong_if #(
  parameter int N_ACT_CH   = 2,
  parameter int N_WGT_CH   = 2,
  parameter int ACT_ADDR_W = 10,
  parameter int WGT_ADDR_W = 10,
  parameter int CNT_W      = 16
) ();
  logic [CNT_W-1:0]          cfg_act_times;
  logic [N_WGT_CH*CNT_W-1:0] cfg_wgt_times;
  logic                      ld_tile_start;
  logic                      ld_tile_ready;
  logic                      ld_valid_act;
  logic                      ld_ready_act;
  logic                      ld_valid_wgt;
  logic                      ld_ready_wgt;
  logic [N_ACT_CH-1:0]       act_buf_ld_en;
  logic [ACT_ADDR_W-1:0]     act_buf_ld_addr;
  logic [N_WGT_CH-1:0]       wgt_buf_ld_en;
  logic [WGT_ADDR_W-1:0]     wgt_buf_ld_addr;
  logic                      ld_bank;
  logic                      ld_tile_end;
  logic                      ex_bank_release;
  logic                      ex_bank_id;
  logic [1:0]                bank_full;

  modport master (
    output cfg_act_times, cfg_wgt_times, ld_tile_start, ld_valid_act, ld_valid_wgt,
           ex_bank_release, ex_bank_id,
    input  ld_tile_ready, ld_ready_act, ld_ready_wgt, act_buf_ld_en, act_buf_ld_addr,
           wgt_buf_ld_en, wgt_buf_ld_addr, ld_bank, ld_tile_end, bank_full
  );

  modport slave (
    input  cfg_act_times, cfg_wgt_times, ld_tile_start, ld_valid_act, ld_valid_wgt,
           ex_bank_release, ex_bank_id,
    output ld_tile_ready, ld_ready_act, ld_ready_wgt, act_buf_ld_en, act_buf_ld_addr,
           wgt_buf_ld_en, wgt_buf_ld_addr, ld_bank, ld_tile_end, bank_full
  );
endinterface

// File: rtl/ctrl_ld_pingpong.sv
// rtl/ctrl_ld_pingpong.sv - tile load controller with ping-pong activation/weight buffer banks
module ctrl_ld_pingpong #(
  parameter int N_ACT_CH   = 2,
  parameter int N_WGT_CH   = 2,
  parameter int ACT_ADDR_W = 10,
  parameter int WGT_ADDR_W = 10,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  ctrl_ld_pingpong_if.slave ld
);
  localparam int SEG_W = (N_WGT_CH > 1) ? $clog2(N_WGT_CH) : 1;

  typedef enum logic [1:0] {A_IDLE, A_RUN, A_DONE} act_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEG, W_DONE} wgt_state_t;

  act_state_t                act_state;
  wgt_state_t                wgt_state;
  logic [CNT_W-1:0]          act_cnt;
  logic [CNT_W-1:0]          act_times;
  logic [CNT_W-1:0]          wgt_cnt;
  logic [N_WGT_CH*CNT_W-1:0] wgt_times;
  logic [SEG_W-1:0]          seg_idx;
  logic                      ld_bank;
  logic [1:0]                bank_full;
  logic [1:0]                bank_full_nxt;
  logic                      start_fire;
  logic                      act_fire;
  logic                      wgt_fire;
  logic                      tile_end;
  logic                      first_found;
  logic                      next_found;
  logic [SEG_W-1:0]          first_seg;
  logic [SEG_W-1:0]          next_seg;
  logic [CNT_W-1:0]          seg_times;

  assign tile_end         = (act_state == A_DONE) && (wgt_state == W_DONE);
  assign ld.ld_tile_ready = (act_state == A_IDLE) && (wgt_state == W_IDLE) && !tile_end
                            && !bank_full[ld_bank];
  assign start_fire       = ld.ld_tile_start && ld.ld_tile_ready;
  assign ld.ld_ready_act  = (act_state == A_RUN);
  assign ld.ld_ready_wgt  = (wgt_state == W_SEG);
  assign act_fire         = ld.ld_valid_act && ld.ld_ready_act;
  assign wgt_fire         = ld.ld_valid_wgt && ld.ld_ready_wgt;
  assign seg_times        = wgt_times[int'(seg_idx)*CNT_W +: CNT_W];

  assign ld.act_buf_ld_en   = {N_ACT_CH{act_fire}};
  assign ld.act_buf_ld_addr = act_cnt[ACT_ADDR_W-1:0];
  assign ld.wgt_buf_ld_en   = wgt_fire ? (N_WGT_CH'(1) << seg_idx) : '0;
  assign ld.wgt_buf_ld_addr = wgt_cnt[WGT_ADDR_W-1:0];
  assign ld.ld_bank         = ld_bank;
  assign ld.ld_tile_end     = tile_end;
  assign ld.bank_full       = bank_full;

  // Descending scan so the lowest qualifying segment index is the one left standing.
  always_comb begin
    first_found = 1'b0;
    first_seg   = '0;
    next_found  = 1'b0;
    next_seg    = '0;
    for (int k = N_WGT_CH-1; k >= 0; k--) begin
      if (ld.cfg_wgt_times[k*CNT_W +: CNT_W] != '0) begin
        first_found = 1'b1;
        first_seg   = SEG_W'(k);
      end
      if ((k > int'(seg_idx)) && (wgt_times[k*CNT_W +: CNT_W] != '0)) begin
        next_found = 1'b1;
        next_seg   = SEG_W'(k);
      end
    end
  end

  // A bank being filled cannot be released at the same time, so the set wins.
  always_comb begin
    bank_full_nxt = bank_full;
    if (ld.ex_bank_release) bank_full_nxt[ld.ex_bank_id] = 1'b0;
    if (tile_end)           bank_full_nxt[ld_bank]       = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_state <= A_IDLE;
      wgt_state <= W_IDLE;
      act_cnt   <= '0;
      act_times <= '0;
      wgt_cnt   <= '0;
      wgt_times <= '0;
      seg_idx   <= '0;
      ld_bank   <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= bank_full_nxt;
      if (start_fire) begin
        act_times <= ld.cfg_act_times;
        wgt_times <= ld.cfg_wgt_times;
        act_state <= (ld.cfg_act_times == '0) ? A_DONE : A_RUN;
        wgt_state <= first_found ? W_SEG : W_DONE;
        seg_idx   <= first_seg;
      end else if (tile_end) begin
        act_state <= A_IDLE;
        wgt_state <= W_IDLE;
        ld_bank   <= ~ld_bank;
      end else begin
        if (act_fire) begin
          if (act_cnt == act_times - CNT_W'(1)) begin
            act_state <= A_DONE;
            act_cnt   <= '0;
          end else begin
            act_cnt <= act_cnt + CNT_W'(1);
          end
        end
        if (wgt_fire) begin
          if (wgt_cnt == seg_times - CNT_W'(1)) begin
            wgt_cnt <= '0;
            if (next_found) seg_idx   <= next_seg;
            else            wgt_state <= W_DONE;
          end else begin
            wgt_cnt <= wgt_cnt + CNT_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ctrl_ld_pingpong.sv
// tb/tb_ctrl_ld_pingpong.sv - directed self-checking bench for ctrl_ld_pingpong
module tb_ctrl_ld_pingpong;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ctrl_ld_pingpong_if bus ();

  ctrl_ld_pingpong dut (
    .clk (clk),
    .rst (rst),
    .ld  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive valids, check stream outputs at negedge, step past posedge.
  task automatic cyc(input string t, input int va, input int vw, input int ra, input int rw,
                     input int ae, input int aa, input int we, input int wa, input int te);
    bus.ld_valid_act = va[0];
    bus.ld_valid_wgt = vw[0];
    @(negedge clk);
    chk({t, ".rdy_act"},  32'(bus.ld_ready_act),    ra);
    chk({t, ".rdy_wgt"},  32'(bus.ld_ready_wgt),    rw);
    chk({t, ".act_en"},   32'(bus.act_buf_ld_en),   ae);
    chk({t, ".act_addr"}, 32'(bus.act_buf_ld_addr), aa);
    chk({t, ".wgt_en"},   32'(bus.wgt_buf_ld_en),   we);
    chk({t, ".wgt_addr"}, 32'(bus.wgt_buf_ld_addr), wa);
    chk({t, ".end"},      32'(bus.ld_tile_end),     te);
    @(posedge clk);
    #1;
  endtask

  task automatic bank_step(input string t, input int bf, input int lb, input int rdy);
    @(negedge clk);
    chk({t, ".bank_full"}, 32'(bus.bank_full),     bf);
    chk({t, ".ld_bank"},   32'(bus.ld_bank),       lb);
    chk({t, ".ready"},     32'(bus.ld_tile_ready), rdy);
    chk({t, ".end"},       32'(bus.ld_tile_end),   0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input string t, input int act, input int w0, input int w1,
                            input int bank);
    bus.cfg_act_times = 16'(act);
    bus.cfg_wgt_times = {16'(w1), 16'(w0)};
    bus.ld_tile_start = 1'b1;
    @(negedge clk);
    chk({t, ".ready"},   32'(bus.ld_tile_ready), 1);
    chk({t, ".ld_bank"}, 32'(bus.ld_bank),       bank);
    @(posedge clk);
    #1;
    bus.ld_tile_start = 1'b0;
    bus.cfg_act_times = '0;
    bus.cfg_wgt_times = '0;
  endtask

  initial begin
    rst                 = 1'b1;
    bus.cfg_act_times   = '0;
    bus.cfg_wgt_times   = '0;
    bus.ld_tile_start   = 1'b0;
    bus.ld_valid_act    = 1'b0;
    bus.ld_valid_wgt    = 1'b0;
    bus.ex_bank_release = 1'b0;
    bus.ex_bank_id      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    cyc("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bank_step("rst", 0, 0, 1);

    // act=4, wgt seg0=3 seg1=2, valids always high
    start_tile("t1", 4, 3, 2, 0);
    cyc("t1c1", 1, 1, 1, 1, 3, 0, 1, 0, 0);
    cyc("t1c2", 1, 1, 1, 1, 3, 1, 1, 1, 0);
    cyc("t1c3", 1, 1, 1, 1, 3, 2, 1, 2, 0);
    cyc("t1c4", 1, 1, 1, 1, 3, 3, 2, 0, 0);
    cyc("t1c5", 1, 1, 0, 1, 0, 0, 2, 1, 0);
    cyc("t1c6", 1, 1, 0, 0, 0, 0, 0, 0, 1);
    bank_step("t1end", 1, 1, 1);

    // second tile into bank1, then a start that must be ignored
    start_tile("t2", 2, 1, 0, 1);
    cyc("t2c1", 1, 1, 1, 1, 3, 0, 1, 0, 0);
    cyc("t2c2", 1, 1, 1, 0, 3, 1, 0, 0, 0);
    cyc("t2c3", 1, 1, 0, 0, 0, 0, 0, 0, 1);
    bus.ld_tile_start = 1'b1;
    bank_step("t2full", 3, 0, 0);
    cyc("t2ign", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    bus.ld_tile_start   = 1'b0;
    bus.ex_bank_release = 1'b1;
    bus.ex_bank_id      = 1'b0;
    bank_step("t2rel", 3, 0, 0);
    bus.ex_bank_release = 1'b0;
    bank_step("t2free", 2, 0, 1);

    // act=0, seg0 empty, seg1=5
    start_tile("t3", 0, 0, 5, 0);
    cyc("t3c1", 1, 1, 0, 1, 0, 0, 2, 0, 0);
    cyc("t3c2", 1, 1, 0, 1, 0, 0, 2, 1, 0);
    cyc("t3c3", 1, 1, 0, 1, 0, 0, 2, 2, 0);
    cyc("t3c4", 1, 1, 0, 1, 0, 0, 2, 3, 0);
    cyc("t3c5", 1, 1, 0, 1, 0, 0, 2, 4, 0);
    cyc("t3c6", 1, 1, 0, 0, 0, 0, 0, 0, 1);
    bank_step("t3end", 3, 1, 0);
    bus.ex_bank_release = 1'b1;
    bus.ex_bank_id      = 1'b1;
    bank_step("t3rel", 3, 1, 0);
    bus.ex_bank_release = 1'b0;
    bank_step("t3free", 1, 1, 1);

    // gapped valids, act done 10 cycles before wgt; tile_end coincides with release of bank0
    start_tile("t4", 2, 3, 2, 1);
    cyc("t4c1",  1, 0, 1, 1, 3, 0, 0, 0, 0);
    cyc("t4c2",  0, 1, 1, 1, 0, 1, 1, 0, 0);
    cyc("t4c3",  1, 0, 1, 1, 3, 1, 0, 1, 0);
    cyc("t4c4",  1, 0, 0, 1, 0, 0, 0, 1, 0);
    cyc("t4c5",  1, 1, 0, 1, 0, 0, 1, 1, 0);
    cyc("t4c6",  1, 0, 0, 1, 0, 0, 0, 2, 0);
    cyc("t4c7",  1, 0, 0, 1, 0, 0, 0, 2, 0);
    cyc("t4c8",  1, 1, 0, 1, 0, 0, 1, 2, 0);
    cyc("t4c9",  1, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("t4c10", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("t4c11", 1, 1, 0, 1, 0, 0, 2, 0, 0);
    cyc("t4c12", 1, 0, 0, 1, 0, 0, 0, 1, 0);
    cyc("t4c13", 1, 1, 0, 1, 0, 0, 2, 1, 0);
    bus.ex_bank_release = 1'b1;
    bus.ex_bank_id      = 1'b0;
    cyc("t4c14", 1, 1, 0, 0, 0, 0, 0, 0, 1);
    bus.ex_bank_release = 1'b0;
    bank_step("t6", 2, 0, 1);

    // reset in the middle of an act stream
    start_tile("t5", 4, 2, 0, 0);
    cyc("t5c1", 1, 1, 1, 1, 3, 0, 1, 0, 0);
    cyc("t5c2", 1, 1, 1, 1, 3, 1, 1, 1, 0);
    rst = 1'b1;
    cyc("t5c3", 1, 1, 1, 0, 3, 2, 0, 0, 0);
    rst = 1'b0;
    cyc("t5rst", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    bank_step("t5rst", 0, 0, 1);
    start_tile("t5b", 2, 1, 1, 0);
    cyc("t5bc1", 1, 1, 1, 1, 3, 0, 1, 0, 0);
    cyc("t5bc2", 1, 1, 1, 1, 3, 1, 2, 0, 0);
    cyc("t5bc3", 1, 1, 0, 0, 0, 0, 0, 0, 1);
    bank_step("t5bend", 1, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
